// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, ACK levels and address type for the I2C target
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } i2c_state_e;
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;
    typedef logic [6:0] i2c_addr_t;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: synchronises SCL/SDA and emits registered START, STOP and SCL edge pulses
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_smp
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_s, sda_s, scl_p, sda_p;
    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];
    // Chains reset to 1 so an idle bus produces no spurious edges after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q    <= '1;
            sda_q    <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda_smp  <= 1'b1;
        end else begin
            scl_q    <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q    <= {sda_q[SYNC_STAGES-2:0], sda};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
            scl_rise <= scl_s & ~scl_p;
            scl_fall <= ~scl_s & scl_p;
            start    <= scl_s & scl_p & sda_p & ~sda_s;
            stop     <= scl_s & scl_p & ~sda_p & sda_s;
            sda_smp  <= sda_s;
        end
    end
endmodule

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: 7-bit addressed I2C target assembling write words and serving reads
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter int        DATA_WIDTH  = 32,
    parameter i2c_addr_t SLAVE_ADDR  = 7'h50,
    parameter int        SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [DATA_WIDTH-1:0] data_r,
    output logic                  data_r_vld,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic                  data_w_vld,
    output logic                  data_w_rdy,
    output logic                  busy,
    output logic                  tx_underrun
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;

    i2c_state_e state;
    logic [BW-1:0] byte_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] sh;
    logic [DATA_WIDTH-1:0] acc, tx_sh, tx_buf, tx_src;
    logic [DATA_WIDTH+7:0] acc_next;
    logic tx_full, oe, rw, last_bit, last_byte, first_tx, consume;
    logic scl_rise, scl_fall, start, stop, sda_smp;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda_smp(sda_smp)
    );

    assign last_bit   = bit_cnt == 3'd7;
    assign last_byte  = byte_cnt == BW'(NB - 1);
    assign first_tx   = state == TX_BYTE && bit_cnt == 3'd0 && byte_cnt == '0;
    assign consume    = scl_fall && first_tx;
    // The word is latched from the buffer on the SCL fall that starts its first byte
    assign tx_src     = first_tx ? (tx_full ? tx_buf : '1) : tx_sh;
    assign acc_next   = {acc, sh, sda_smp};
    assign data_w_rdy = !tx_full;
    assign sda        = (oe && !rst) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            acc         <= '0;
            tx_sh       <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            oe          <= 1'b0;
            rw          <= 1'b0;
            busy        <= 1'b0;
            data_r      <= '0;
            data_r_vld  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            data_r_vld  <= 1'b0;
            tx_underrun <= 1'b0;
            if (consume) tx_full <= 1'b0;
            if (data_w_vld && (!tx_full || consume)) begin
                tx_buf  <= data_w;
                tx_full <= 1'b1;
            end
            if (start) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                oe       <= 1'b0;
            end else if (stop) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                oe       <= 1'b0;
                busy     <= 1'b0;
            end else if (scl_fall) begin
                oe <= state == ADDR_ACK || state == RX_ACK || (state == TX_BYTE && !tx_src[DATA_WIDTH-1]);
                if (state == TX_BYTE) tx_sh <= tx_src << 1;
                if (consume && !tx_full) tx_underrun <= 1'b1;
            end else if (scl_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                case (state)
                    ADDR: begin
                        sh <= {sh[5:0], sda_smp};
                        if (last_bit) begin
                            rw    <= sda_smp;
                            busy  <= sh == SLAVE_ADDR;
                            state <= sh == SLAVE_ADDR ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt <= '0;
                        state   <= rw ? TX_BYTE : RX_BYTE;
                    end
                    RX_BYTE: begin
                        sh <= {sh[5:0], sda_smp};
                        if (last_bit) begin
                            acc      <= acc_next[DATA_WIDTH-1:0];
                            state    <= RX_ACK;
                            byte_cnt <= last_byte ? '0 : byte_cnt + BW'(1);
                            if (last_byte) begin
                                data_r     <= acc_next[DATA_WIDTH-1:0];
                                data_r_vld <= 1'b1;
                            end
                        end
                    end
                    RX_ACK: begin
                        bit_cnt <= '0;
                        state   <= RX_BYTE;
                    end
                    TX_BYTE: begin
                        if (last_bit) begin
                            state    <= TX_ACK;
                            byte_cnt <= last_byte ? '0 : byte_cnt + BW'(1);
                        end
                    end
                    TX_ACK: begin
                        bit_cnt <= '0;
                        busy    <= sda_smp == ACK;
                        state   <= sda_smp == ACK ? TX_BYTE : WAIT_STOP;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: bit-level I2C master with a transaction-level model of the target
module tb_i2c_slave_ctrl;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1, data_w_vld = 1'b0;
    logic [31:0] data_w = '0, data_r;
    logic data_r_vld, data_w_rdy, busy, tx_underrun;
    wire sda;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;
    always #5 clk = ~clk;

    i2c_slave_ctrl dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .data_r(data_r), .data_r_vld(data_r_vld),
        .data_w(data_w), .data_w_vld(data_w_vld), .data_w_rdy(data_w_rdy),
        .busy(busy), .tx_underrun(tx_underrun)
    );

    int checks = 0, fails = 0, vld_seen = 0, unr_seen = 0, unr_exp = 0;
    logic may_drive = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] m_acc = '0, m_buf = '0, m_word = '0;
    int m_cnt = 0, m_idx = 0;
    logic m_full = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: writes pack into 4-byte words; START/STOP drop partial words
    function automatic void m_rx(input logic [7:0] b);
        m_acc = {m_acc[23:0], b};
        m_cnt++;
        if (m_cnt == 4) begin
            exp_q.push_back(m_acc);
            m_cnt = 0;
        end
    endfunction

    function automatic void m_restart();
        m_cnt = 0;
        m_idx = 0;
    endfunction

    function automatic void m_load(input logic [31:0] v);
        if (!m_full) begin
            m_buf  = v;
            m_full = 1'b1;
        end
    endfunction

    function automatic logic [7:0] m_tx();
        logic [7:0] b;
        if (m_idx == 0) begin
            m_word = m_full ? m_buf : 32'hFFFF_FFFF;
            if (!m_full) unr_exp++;
            m_full = 1'b0;
        end
        b = m_word[31 - 8*m_idx -: 8];
        m_idx = (m_idx + 1) % 4;
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (data_r_vld) begin
                vld_seen++;
                if (exp_q.size() == 0) chk("unexpected data_r_vld", data_r_vld, 0);
                else chk("data_r word", data_r, exp_q.pop_front());
            end
            if (tx_underrun) unr_seen++;
            if (m_sda && !may_drive) chk("sda released", sda, 1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time bound expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bit_io(input logic b, input logic drv, output logic r);
        may_drive = may_drive | drv;
        tick(6);
        m_sda = b;
        may_drive = drv;
        tick(6);
        scl = 1'b1;
        tick(5);
        @(negedge clk) r = sda;
        tick(5);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        tick(6);
        m_sda = 1'b1;
        may_drive = 1'b0;
        tick(6);
        scl = 1'b1;
        tick(6);
        m_sda = 1'b0;
        tick(6);
        scl = 1'b0;
        m_restart();
    endtask

    task automatic stop_cond();
        tick(6);
        m_sda = 1'b0;
        may_drive = 1'b0;
        tick(6);
        scl = 1'b1;
        tick(6);
        m_sda = 1'b1;
        tick(6);
        m_restart();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic drv_ack, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], 1'b0, r);
        bit_io(1'b1, drv_ack, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        logic r;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, 1'b1, r);
            b = {b[6:0], r};
        end
        bit_io(m_ack, 1'b0, r);
    endtask

    task automatic load(input logic [31:0] v);
        @(negedge clk);
        data_w = v;
        data_w_vld = 1'b1;
        m_load(v);
        @(negedge clk);
        data_w_vld = 1'b0;
    endtask

    initial begin
        logic a, r;
        logic [7:0] b, e;
        logic [31:0] w;
        logic [7:0] wr1[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] wr6[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] a0 = 8'hA0;
        tick(4);
        @(negedge clk) rst = 1'b0;
        chk("reset data_r", data_r, 0);
        chk("reset data_r_vld", data_r_vld, 0);
        chk("reset data_w_rdy", data_w_rdy, 1);
        chk("reset busy", busy, 0);
        chk("reset tx_underrun", tx_underrun, 0);
        chk("reset sda", sda, 1);

        // Write DEADBEEF to 0x50
        start_cond();
        write_byte(8'hA0, 1'b1, a);
        chk("addr A0 ack", a, 0);
        @(negedge clk) chk("busy after match", busy, 1);
        for (int i = 0; i < 4; i++) begin
            m_rx(wr1[i]);
            write_byte(wr1[i], 1'b1, a);
            chk("write byte ack", a, 0);
        end
        stop_cond();
        chk("busy after stop", busy, 0);
        chk("data_r DEADBEEF", data_r, 32'hDEADBEEF);
        chk("vld count t1", vld_seen, 1);

        // Wrong address 0x51
        start_cond();
        write_byte(8'hA2, 1'b0, a);
        chk("addr A2 nack", a, 1);
        chk("busy on mismatch", busy, 0);
        write_byte(8'h33, 1'b0, a);
        chk("mismatch data nack", a, 1);
        stop_cond();
        chk("vld count t2", vld_seen, 1);

        // Preloaded read; second load while full must be ignored
        load(32'h12345678);
        chk("rdy after load", data_w_rdy, 0);
        load(32'hFFFF0000);
        chk("rdy still full", data_w_rdy, 0);
        start_cond();
        write_byte(8'hA1, 1'b1, a);
        chk("addr A1 ack", a, 0);
        w = '0;
        for (int i = 0; i < 4; i++) begin
            e = m_tx();
            read_byte(i == 3, b);
            chk("read byte", b, e);
            w = {w[23:0], b};
            if (i == 0) chk("rdy after first byte", data_w_rdy, 1);
        end
        chk("read word 12345678", w, 32'h12345678);
        stop_cond();
        chk("busy after read", busy, 0);
        chk("no underrun t3", unr_seen, 0);

        // Empty buffer: 5 bytes span two words
        start_cond();
        write_byte(8'hA1, 1'b1, a);
        chk("addr A1 ack t4", a, 0);
        for (int i = 0; i < 5; i++) begin
            e = m_tx();
            read_byte(i == 4, b);
            chk("underrun byte model", b, e);
            chk("underrun byte FF", b, 8'hFF);
        end
        stop_cond();
        chk("underrun count model", unr_seen, unr_exp);
        chk("underrun count 2", unr_seen, 2);

        // Partial write then repeated START read
        load(32'hCAFEF00D);
        start_cond();
        write_byte(8'hA0, 1'b1, a);
        chk("addr A0 ack t5", a, 0);
        m_rx(8'h11);
        write_byte(8'h11, 1'b1, a);
        m_rx(8'h22);
        write_byte(8'h22, 1'b1, a);
        chk("byte 22 ack", a, 0);
        start_cond();
        write_byte(8'hA1, 1'b1, a);
        chk("restart addr ack", a, 0);
        e = m_tx();
        read_byte(1'b0, b);
        chk("restart byte0 model", b, e);
        chk("restart byte0 CA", b, 8'hCA);
        e = m_tx();
        read_byte(1'b1, b);
        chk("restart byte1 model", b, e);
        chk("restart byte1 FE", b, 8'hFE);
        stop_cond();
        chk("vld count t5", vld_seen, 1);

        // Reset while driving the address ACK
        start_cond();
        for (int i = 7; i >= 0; i--) bit_io(a0[i], 1'b0, r);
        may_drive = 1'b1;
        tick(6);
        m_sda = 1'b1;
        tick(2);
        @(negedge clk) chk("ack driven before reset", sda, 0);
        rst = 1'b1;
        @(negedge clk) chk("sda released in reset", sda, 1);
        may_drive = 1'b0;
        m_full = 1'b0;
        tick(3);
        @(negedge clk) rst = 1'b0;
        chk("data_r after reset", data_r, 0);
        chk("busy after reset", busy, 0);
        stop_cond();
        start_cond();
        write_byte(8'hA0, 1'b1, a);
        chk("addr ack after reset", a, 0);
        for (int i = 0; i < 4; i++) begin
            m_rx(wr6[i]);
            write_byte(wr6[i], 1'b1, a);
            chk("post-reset byte ack", a, 0);
        end
        stop_cond();
        chk("data_r 01020304", data_r, 32'h01020304);
        chk("vld count t6", vld_seen, 2);
        chk("words outstanding", exp_q.size(), 0);
        chk("underrun final", unr_seen, unr_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
